// File: rtl/mac_nn_bit_1cc_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_nn_bit_1cc_if
// Description : Operand/result bundle for the one-pair-per-cycle signed MAC.
//               The master drives operand pairs and observes the running sum.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_nn_bit_1cc_if #(
    parameter int N = 8,
    parameter int K = 3
);
    logic signed [N-1:0]       g_input;
    logic signed [N-1:0]       e_input;
    logic signed [2*N+K-2:0]   o;

    modport master (
        output g_input,
        output e_input,
        input  o
    );

    modport slave (
        input  g_input,
        input  e_input,
        output o
    );
endinterface
`default_nettype wire

// File: rtl/mac_nn_bit_1cc.sv
`default_nettype none
// ============================================================================
// Module      : mac_nn_bit_1cc
// Description : Signed N-bit multiply-accumulate, one operand pair per clock.
//               The output shows the running dot product including the pair
//               presented this cycle (zero-latency); the accumulator wraps
//               modulo 2^(2N+K-1) and runs until the caller resets it.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_nn_bit_1cc #(
    parameter int N = 8,
    parameter int K = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mac_nn_bit_1cc_if.slave      bus
);
    localparam int W = 2 * N + K - 1;

    logic signed [2*N-1:0] prod;
    logic signed [W-1:0]   prod_ext;
    logic signed [W-1:0]   sum;
    logic signed [W-1:0]   acc_d;
    logic signed [W-1:0]   acc_q;

    // Full signed product, sign-extended into the accumulator width, plus running sum.
    always_comb begin
        prod     = (2*N)'(bus.g_input) * (2*N)'(bus.e_input);
        prod_ext = W'(prod);
        sum      = acc_q + prod_ext;
        acc_d    = rst ? '0 : sum;
        bus.o    = rst ? '0 : sum;
    end

    // Accumulator register: cleared by reset, otherwise absorbs this cycle's product.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end
endmodule
`default_nettype wire

// File: tb/tb_mac_nn_bit_1cc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_nn_bit_1cc
// Description : Directed, table-driven bench for mac_nn_bit_1cc (N=8, K=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_nn_bit_1cc;
    localparam int N = 8;
    localparam int K = 3;
    localparam int W = 2 * N + K - 1;

    typedef struct {
        logic                rst;
        logic signed [N-1:0] g;
        logic signed [N-1:0] e;
        logic signed [W-1:0] exp_o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mac_nn_bit_1cc_if #(.N(N), .K(K)) bus ();

    mac_nn_bit_1cc #(.N(N), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input int r, input int g, input int e, input int o);
        vec_t v;
        v.rst   = r[0];
        v.g     = N'(g);
        v.e     = N'(e);
        v.exp_o = W'(o);
        vecs.push_back(v);
    endtask

    // Drive one cycle after the falling edge, check mid-cycle, then let the rising edge pass.
    task automatic apply(input logic r, input logic signed [N-1:0] g,
                         input logic signed [N-1:0] e, input logic signed [W-1:0] exp_o,
                         input string name);
        @(negedge clk);
        rst         = r;
        bus.g_input = g;
        bus.e_input = e;
        #1;
        n_cmp++;
        if (bus.o !== exp_o) begin
            n_bad++;
            $display("FAIL %s: o got %0d (0x%05h) expected %0d (0x%05h)",
                     name, bus.o, bus.o, exp_o, exp_o);
        end
        @(posedge clk);
    endtask

    initial begin
        logic signed [W-1:0] model;

        bus.g_input = '0;
        bus.e_input = '0;

        // Reset behaviour
        add(1,    5,   7,      0);
        add(1,    5,   7,      0);
        add(0,    0,   0,      0);
        // Dot product G={29,74,-39}, E={-38,-91,47}
        add(0,   29, -38,  -1102);
        add(0,   74, -91,  -7836);
        add(0,  -39,  47,  -9669);
        // Extremes
        add(1,    1,   1,      0);
        add(0, -128, -128, 16384);
        add(0, -128, -128, 32768);
        add(0, -128, -128, 49152);
        add(0, -128,  127, 32896);
        // Mid-run reset with nonzero inputs
        add(1,    0,   0,      0);
        add(0,   10,  10,    100);
        add(0,   10,  10,    200);
        add(1,   10,  10,      0);
        add(0,    3,  -4,    -12);
        // Idle hold
        add(0,    0,   0,    -12);
        add(0,    0,   0,    -12);
        add(0,    0,   0,    -12);
        add(0,   20,   5,     88);
        add(0,    0,   0,     88);
        add(0,    0,   0,     88);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].g, vecs[i].e, vecs[i].exp_o, $sformatf("vec%0d", i));
        end

        // Wrap: 17 consecutive (-128)*(-128) products, modulo 2^18
        apply(1'b1, 8'sd1, 8'sd1, '0, "wrap_rst");
        model = '0;
        for (int i = 1; i <= 17; i++) begin
            model = model + W'(16384);
            apply(1'b0, -8'sd128, -8'sd128, model, $sformatf("wrap%0d", i));
        end
        // Pair 16 lands exactly on 2^18 (wraps to 0); pair 17 gives 16384 again.
        n_cmp++;
        if (model !== W'(16384)) begin
            n_bad++;
            $display("FAIL wrap_model: got %0d expected 16384", model);
        end
        // After wrap, zero pairs hold the value
        apply(1'b0, 8'sd0, 8'sd0, W'(16384), "wrap_hold");
        // Most negative times most positive from a fresh start
        apply(1'b1, 8'sd0, 8'sd0, '0, "mix_rst");
        apply(1'b0, -8'sd128, 8'sd127, -W'(16256), "mix_neg");
        apply(1'b0, 8'sd127, 8'sd127, W'(-16256 + 16129), "mix_pos");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_nn_bit_1cc.md
Name: mac_nn_bit_1cc

Overview:
Signed N-bit multiply-accumulate unit that consumes one operand pair per clock cycle. Used as the datapath of a sequential K-dimension vector dot product: K consecutive cycles of (g, e) pairs produce sum(g[i]*e[i]). Output width 2N+K-1 bits.

Parameters:
N, 8, bit-width of each signed input operand.
K, 3, vector dimension (number of accumulated products); sets output growth bits.

Ports:
clk  input  1  clock, rising edge active.
rst  input  1  synchronous, active-high reset.
g_input  input  N  signed operand A (two's complement).
e_input  input  N  signed operand B (two's complement).
o  output  2N+K-1  signed running dot product, including the current cycle's product.

Behaviour:
- Reset is synchronous and active-high on clock clk (rst).
- Internal state: one signed accumulator register acc of width 2N+K-1.
- Product p = g_input * e_input:
  - full 2N-bit signed multiply;
  - sign-extended to 2N+K-1 bits.
- Output is combinational from acc and the current inputs:
  - o = acc + p when rst = 0;
  - o = 0 while rst = 1.
- Latency: zero cycles to o. The current pair is visible on o in the same cycle it is applied.
- On each rising clk edge:
  - rst = 1: acc <= 0;
  - otherwise: acc <= acc + p, which equals the o value just before the edge.
- After reset release, with pairs (g0, e0) … (gK-1, eK-1) applied in consecutive cycles:
  - o during the cycle holding pair j = sum over i = 0..j of gi*ei;
  - o during the last pair = full dot product.
- Arithmetic: two's complement, modulo 2^(2N+K-1).
  - No saturation and no overflow flag.
  - Sums beyond K full-scale products wrap silently.
- Accumulation is free-running. It never stops at K; the caller resets between vectors.
- Zero inputs (0, 0) hold acc unchanged, so idle cycles are harmless.
- Reset mid-accumulation:
  - o goes to 0 immediately;
  - acc is 0 after the edge;
  - the next pair starts a fresh sum.
- Extreme operands must produce the correct signed product:
  - (-2^(N-1)) * (-2^(N-1)) = +2^(2N-2);
  - requires sign-correct multiply, not unsigned.
- No handshake; every non-reset cycle accumulates.

Test Plan:
- Reset: rst = 1 with g = 5, e = 7 -> o = 0. After one edge acc = 0. Release with g = e = 0 -> o = 0.
- Dot product, N = 8, K = 3, G = {29, 74, -39}, E = {-38, -91, 47} on consecutive cycles after reset:
  - o = -1102 (0x3FBB2) during pair 0;
  - o = -7836 (0x3E164) during pair 1;
  - o = -9669 (0x3DA3B) during pair 2.
- Extremes: g = -128, e = -128 for 3 cycles -> o = 16384, 32768, 49152. Then g = -128, e = 127 -> o = 49152 - 16256 = 32896.
- Mid-run reset: accumulate 10*10 twice (o = 200), assert rst for one cycle with inputs nonzero -> o = 0 during reset. Then g = 3, e = -4 -> o = -12.
- Wrap: keep g = e = -128 beyond K cycles -> o wraps modulo 2^18. For example, after 16 accumulated products of 16384 (acc = 262144 ≡ 0), the current pair -128*-128 gives o = 16384.
- Idle hold: after a nonzero sum S, apply g = 0, e = 0 for several cycles -> o stays at S.
